// File: rtl/riscv_defines.sv
// Shared CSR definitions: operation codes, the performance-counter address map,
// the counter configuration layout and the common CSR read-modify-write helper.
package riscv_defines;

    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam logic [11:0] PERF_CNTLO_BASE = 12'h780;
    localparam logic [11:0] PERF_CNTHI_BASE = 12'h788;
    localparam logic [11:0] PERF_CFG_BASE   = 12'h790;
    localparam logic [11:0] PERF_GCTRL      = 12'h7A0;
    localparam logic [11:0] PERF_OVF        = 12'h7A1;

    localparam int unsigned PERF_CFG_SEL_LSB = 0;
    localparam int unsigned PERF_CFG_SEL_W   = 8;
    localparam int unsigned PERF_CFG_EN_BIT  = 8;
    localparam int unsigned PERF_CFG_SAT_BIT = 9;
    localparam int unsigned PERF_CFG_IRQ_BIT = 10;
    localparam int unsigned PERF_CFG_OVF_BIT = 31;

    // Packed so that a cast of CFG bits [10:0] lands on the right fields.
    typedef struct packed {
        logic       irq_en;
        logic       sat;
        logic       en;
        logic [7:0] evt_sel;
    } perf_cfg_t;

    function automatic logic [31:0] csr_apply_op(input logic [1:0]  op,
                                                 input logic [31:0] old_v,
                                                 input logic [31:0] wdata);
        case (op)
            CSR_OP_WRITE: csr_apply_op = wdata;
            CSR_OP_SET:   csr_apply_op = old_v | wdata;
            CSR_OP_CLEAR: csr_apply_op = old_v & ~wdata;
            default:      csr_apply_op = old_v;
        endcase
    endfunction

endpackage

// File: rtl/riscv_perf_counter_slice.sv
// One performance counter: configuration, one-cycle event pipeline (inc_q),
// increment with saturate/wrap, sticky overflow flag and its CSR write port.
module riscv_perf_counter_slice
    import riscv_defines::*;
#(
    parameter int unsigned N_EVENTS = 16,
    parameter int unsigned CNT_W    = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_EVENTS-1:0] events_i,
    input  logic                count_en_i,
    input  logic                wr_lo_i,
    input  logic                wr_hi_i,
    input  logic                wr_cfg_i,
    input  logic                wr_ovf_i,
    input  logic [31:0]         wdata_i,
    input  logic                ovf_wval_i,
    output logic [CNT_W-1:0]    cnt_o,
    output perf_cfg_t           cfg_o,
    output logic                ovf_o,
    output logic                irq_pend_d_o
);

    localparam int unsigned HI_W = CNT_W - 32;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    perf_cfg_t        cfg_q, cfg_d;
    logic             inc_q, inc_d;
    logic             ovf_q, ovf_d;
    logic             ovf_set_s;
    logic [255:0]     evt_pad_s;

    // Event selection and next-state for counter, config and overflow flag.
    always_comb begin
        evt_pad_s = 256'(events_i);
        inc_d     = count_en_i & cfg_q.en & evt_pad_s[cfg_q.evt_sel];
        cnt_d     = cnt_q;
        ovf_set_s = 1'b0;
        if (wr_lo_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            // Carry out of the low word is dropped when the high word is written.
            cnt_d[CNT_W-1:32] = wdata_i[HI_W-1:0];
            cnt_d[31:0]       = inc_q ? (cnt_q[31:0] + 32'd1) : cnt_q[31:0];
        end else if (inc_q) begin
            if (cnt_q == CNT_MAX) begin
                ovf_set_s = 1'b1;
                cnt_d     = cfg_q.sat ? CNT_MAX : {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end

        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (wr_ovf_i) begin
            ovf_d = ovf_wval_i;
        end else begin
            ovf_d = ovf_q;
        end

        cfg_d        = wr_cfg_i ? perf_cfg_t'(wdata_i[10:0]) : cfg_q;
        irq_pend_d_o = ovf_d & cfg_d.irq_en;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
            cfg_q <= '0;
            inc_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cfg_q <= cfg_d;
            inc_q <= inc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign cfg_o = cfg_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/riscv_perf_counters.sv
// Performance-counter unit: CSR decoder, global control, atomic high-word
// shadow and read mux around N_CNT counter slices.
module riscv_perf_counters
    import riscv_defines::*;
#(
    parameter int unsigned N_EVENTS = 16,
    parameter int unsigned N_CNT    = 4,
    parameter int unsigned CNT_W    = 48
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csr_access_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [31:0]         csr_wdata_i,
    input  logic [1:0]          csr_op_i,
    output logic [31:0]         csr_rdata_o,
    output logic                csr_hit_o,
    input  logic [N_EVENTS-1:0] events_i,
    output logic [N_CNT-1:0]    ovf_o,
    output logic                ovf_irq_o
);

    localparam int unsigned HI_W = CNT_W - 32;

    logic [CNT_W-1:0] cnt_s [N_CNT];
    perf_cfg_t        cfg_s [N_CNT];
    logic [N_CNT-1:0] ovf_s, irq_pend_d_s;

    logic             global_en_q, global_en_d, freeze_q, freeze_d, ovf_irq_q;
    logic [HI_W-1:0]  shadow_q, shadow_d;
    logic [2:0]       tag_q, tag_d;
    logic             tag_vld_q, tag_vld_d;

    logic [2:0]       idx_s;
    logic [11:0]      base_s;
    logic             idx_ok_s, lo_sel_s, hi_sel_s, cfg_sel_s, gctrl_sel_s, ovf_sel_s;
    logic             hit_s, wr_s, count_en_s;
    logic [31:0]      cur_lo_s, cur_hi_s, live_hi32_s, cur_cfg_s, rdata_s, old_s, wval_s;
    logic [HI_W-1:0]  live_hi_s;

    // Address decode, read mux and write-value computation.
    always_comb begin
        idx_s       = csr_addr_i[2:0];
        base_s      = {csr_addr_i[11:3], 3'b000};
        idx_ok_s    = ({1'b0, idx_s} < 4'(N_CNT));
        lo_sel_s    = csr_access_i & idx_ok_s & (base_s == PERF_CNTLO_BASE);
        hi_sel_s    = csr_access_i & idx_ok_s & (base_s == PERF_CNTHI_BASE);
        cfg_sel_s   = csr_access_i & idx_ok_s & (base_s == PERF_CFG_BASE);
        gctrl_sel_s = csr_access_i & (csr_addr_i == PERF_GCTRL);
        ovf_sel_s   = csr_access_i & (csr_addr_i == PERF_OVF);
        hit_s       = lo_sel_s | hi_sel_s | cfg_sel_s | gctrl_sel_s | ovf_sel_s;
        wr_s        = hit_s & (csr_op_i != CSR_OP_NONE);

        cur_lo_s    = 32'd0;
        cur_hi_s    = 32'd0;
        live_hi32_s = 32'd0;
        cur_cfg_s   = 32'd0;
        live_hi_s   = '0;
        for (int i = 0; i < N_CNT; i++) begin
            if (idx_s == 3'(i)) begin
                cur_lo_s  = cnt_s[i][31:0];
                live_hi_s = cnt_s[i][CNT_W-1:32];
                cur_hi_s[HI_W-1:0] = (tag_vld_q && (tag_q == 3'(i))) ? shadow_q
                                                                       : cnt_s[i][CNT_W-1:32];
                cur_cfg_s = {ovf_s[i], 20'd0, cfg_s[i]};
            end else begin
                cur_lo_s = cur_lo_s;
            end
        end
        live_hi32_s[HI_W-1:0] = live_hi_s;

        if (lo_sel_s) begin
            rdata_s = cur_lo_s;
        end else if (hi_sel_s) begin
            rdata_s = cur_hi_s;
        end else if (cfg_sel_s) begin
            rdata_s = cur_cfg_s;
        end else if (gctrl_sel_s) begin
            rdata_s = {30'd0, freeze_q, global_en_q};
        end else if (ovf_sel_s) begin
            rdata_s = 32'(ovf_s);
        end else begin
            rdata_s = 32'd0;
        end

        // Read-modify-write of CNTHI works on the live value, never the shadow.
        old_s  = hi_sel_s ? live_hi32_s : rdata_s;
        wval_s = csr_apply_op(csr_op_i, old_s, csr_wdata_i);
    end

    // Next-state for global control and the CNTLO/CNTHI shadow tag.
    always_comb begin
        global_en_d = global_en_q;
        freeze_d    = freeze_q;
        shadow_d    = shadow_q;
        tag_d       = tag_q;
        tag_vld_d   = tag_vld_q;
        if (wr_s && gctrl_sel_s) begin
            global_en_d = wval_s[0];
            freeze_d    = wval_s[1];
        end else begin
            global_en_d = global_en_q;
        end
        if (lo_sel_s) begin
            shadow_d  = live_hi_s;
            tag_d     = idx_s;
            tag_vld_d = ~wr_s;
        end else if (wr_s && hi_sel_s && (tag_q == idx_s)) begin
            tag_vld_d = 1'b0;
        end else begin
            tag_vld_d = tag_vld_q;
        end
    end

    // Top-level state registers; the interrupt is registered from next-state flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            global_en_q <= 1'b0;
            freeze_q    <= 1'b0;
            shadow_q    <= '0;
            tag_q       <= 3'd0;
            tag_vld_q   <= 1'b0;
            ovf_irq_q   <= 1'b0;
        end else begin
            global_en_q <= global_en_d;
            freeze_q    <= freeze_d;
            shadow_q    <= shadow_d;
            tag_q       <= tag_d;
            tag_vld_q   <= tag_vld_d;
            ovf_irq_q   <= |irq_pend_d_s;
        end
    end

    assign count_en_s = global_en_q & ~(freeze_q & ovf_irq_q);

    for (genvar g = 0; g < N_CNT; g++) begin : g_slice
        riscv_perf_counter_slice #(
            .N_EVENTS(N_EVENTS),
            .CNT_W   (CNT_W)
        ) u_slice (
            .clk         (clk),
            .rst_n       (rst_n),
            .events_i    (events_i),
            .count_en_i  (count_en_s),
            .wr_lo_i     (wr_s & lo_sel_s & (idx_s == 3'(g))),
            .wr_hi_i     (wr_s & hi_sel_s & (idx_s == 3'(g))),
            .wr_cfg_i    (wr_s & cfg_sel_s & (idx_s == 3'(g))),
            .wr_ovf_i    (wr_s & (ovf_sel_s | (cfg_sel_s & (idx_s == 3'(g))))),
            .wdata_i     (wval_s),
            .ovf_wval_i  (ovf_sel_s ? wval_s[g] : wval_s[PERF_CFG_OVF_BIT]),
            .cnt_o       (cnt_s[g]),
            .cfg_o       (cfg_s[g]),
            .ovf_o       (ovf_s[g]),
            .irq_pend_d_o(irq_pend_d_s[g])
        );
    end

    assign csr_rdata_o = rdata_s;
    assign csr_hit_o   = hit_s;
    assign ovf_o       = ovf_s;
    assign ovf_irq_o   = ovf_irq_q;

endmodule

// File: tb/tb_riscv_perf_counters.sv
// Bench for riscv_perf_counters: directed scenarios plus random CSR/event
// traffic, all checked every cycle against a value-level reference model.
module tb_riscv_perf_counters;
    import riscv_defines::*;

    localparam int NE = 16;
    localparam int NC = 4;
    localparam int CW = 48;
    localparam longint unsigned CMAX  = (64'd1 << CW) - 64'd1;
    localparam longint unsigned HMASK = (64'd1 << (CW - 32)) - 64'd1;
    localparam longint unsigned LMASK = 64'hFFFF_FFFF;

    logic          clk = 1'b0, rst_n = 1'b0, acc = 1'b0;
    logic [11:0]   addr = 12'd0;
    logic [31:0]   wdata = 32'd0;
    logic [1:0]    op = 2'd0;
    logic [NE-1:0] ev = '0;
    logic [31:0]   rdata;
    logic          hit, irq;
    logic [NC-1:0] ovf;

    riscv_perf_counters #(.N_EVENTS(NE), .N_CNT(NC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .csr_access_i(acc), .csr_addr_i(addr),
        .csr_wdata_i(wdata), .csr_op_i(op), .csr_rdata_o(rdata), .csr_hit_o(hit),
        .events_i(ev), .ovf_o(ovf), .ovf_irq_o(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [31:0]   last_rd;
    logic [NC-1:0] last_ovf;
    logic          last_irq, last_hit;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: whole counter values and flags.
    longint unsigned m_cnt [NC];
    int              m_sel [NC];
    bit              m_en [NC], m_sat [NC], m_ien [NC], m_ovf [NC], m_pend [NC];
    bit              m_gen, m_frz, m_tvld;
    longint unsigned m_shadow;
    int              m_tag;

    function automatic void m_reset();
        for (int j = 0; j < NC; j++) begin
            m_cnt[j] = 0; m_sel[j] = 0; m_en[j] = 0; m_sat[j] = 0;
            m_ien[j] = 0; m_ovf[j] = 0; m_pend[j] = 0;
        end
        m_gen = 0; m_frz = 0; m_tvld = 0; m_shadow = 0; m_tag = 0;
    endfunction

    // 0 none, 1 CNTLO, 2 CNTHI, 3 CFG, 4 GCTRL, 5 OVF
    function automatic int m_kind(input logic [11:0] a, output int idx);
        int ia = int'(a);
        idx = ia % 8;
        if (ia >= 'h780 && ia < 'h780 + NC) return 1;
        if (ia >= 'h788 && ia < 'h788 + NC) return 2;
        if (ia >= 'h790 && ia < 'h790 + NC) return 3;
        if (ia == 'h7A0) return 4;
        if (ia == 'h7A1) return 5;
        return 0;
    endfunction

    function automatic bit m_irq();
        bit r = 0;
        for (int j = 0; j < NC; j++) r |= m_ovf[j] & m_ien[j];
        return r;
    endfunction

    function automatic longint unsigned m_ovf_vec();
        longint unsigned v = 0;
        for (int j = 0; j < NC; j++) if (m_ovf[j]) v |= (64'd1 << j);
        return v;
    endfunction

    function automatic longint unsigned m_read(input logic [11:0] a, input bit live);
        int i;
        int k = m_kind(a, i);
        case (k)
            1: return m_cnt[i] & LMASK;
            2: return (!live && m_tvld && m_tag == i) ? m_shadow : (m_cnt[i] >> 32);
            3: return (longint'(m_ovf[i]) << 31) | (longint'(m_ien[i]) << 10) |
                      (longint'(m_sat[i]) << 9) | (longint'(m_en[i]) << 8) | longint'(m_sel[i]);
            4: return (longint'(m_frz) << 1) | longint'(m_gen);
            5: return m_ovf_vec();
            default: return 0;
        endcase
    endfunction

    function automatic void m_step(input bit a_acc, input logic [11:0] a, input logic [1:0] o,
                                   input logic [31:0] wd, input logic [NE-1:0] e);
        int i;
        int k = a_acc ? m_kind(a, i) : 0;
        bit wr = (k != 0) && (o != CSR_OP_NONE);
        longint unsigned old = m_read(a, 1);
        longint unsigned w = longint'(wd);
        longint unsigned nv;
        bit frozen = m_frz && m_irq();
        bit newpend [NC];
        case (o)
            CSR_OP_WRITE: nv = w;
            CSR_OP_SET:   nv = old | w;
            CSR_OP_CLEAR: nv = old & ~w & LMASK;
            default:      nv = old;
        endcase
        for (int j = 0; j < NC; j++)
            newpend[j] = m_gen && m_en[j] && !frozen && (m_sel[j] < NE) && e[m_sel[j] % NE];
        if (k == 1) begin
            m_shadow = m_cnt[i] >> 32; m_tag = i; m_tvld = !wr;
        end else if (k == 2 && wr && m_tag == i) begin
            m_tvld = 0;
        end
        for (int j = 0; j < NC; j++) begin
            bit hw = 0;
            if (wr && k == 1 && i == j) begin
                m_cnt[j] = (m_cnt[j] & ~LMASK) | nv;
            end else if (wr && k == 2 && i == j) begin
                longint unsigned lo = m_cnt[j] & LMASK;
                if (m_pend[j]) lo = (lo + 1) & LMASK;
                m_cnt[j] = ((nv & HMASK) << 32) | lo;
            end else if (m_pend[j]) begin
                if (m_cnt[j] == CMAX) begin
                    hw = 1;
                    m_cnt[j] = m_sat[j] ? CMAX : 0;
                end else begin
                    m_cnt[j] = m_cnt[j] + 1;
                end
            end
            if (hw) m_ovf[j] = 1;
            else if (wr && k == 5) m_ovf[j] = nv[j];
            else if (wr && k == 3 && i == j) m_ovf[j] = nv[31];
            if (wr && k == 3 && i == j) begin
                m_sel[j] = int'(nv & 64'hFF); m_en[j] = nv[8]; m_sat[j] = nv[9]; m_ien[j] = nv[10];
            end
            m_pend[j] = newpend[j];
        end
        if (wr && k == 4) begin
            m_gen = nv[0]; m_frz = nv[1];
        end
    endfunction

    // One clock cycle: drive, compare outputs against the model, advance both.
    task automatic cyc(input bit a_acc, input logic [11:0] a, input logic [1:0] o,
                       input logic [31:0] wd, input logic [NE-1:0] e);
        int i;
        int k;
        acc = a_acc; addr = a; op = o; wdata = wd; ev = e;
        #1;
        k = a_acc ? m_kind(a, i) : 0;
        check("hit", hit, (k != 0));
        check("rdata", rdata, (k != 0) ? m_read(a, 0) : 64'd0);
        check("ovf_o", ovf, m_ovf_vec());
        check("ovf_irq_o", irq, m_irq());
        last_rd = rdata; last_ovf = ovf; last_irq = irq; last_hit = hit;
        @(posedge clk);
        m_step(a_acc, a, o, wd, e);
        @(negedge clk);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cyc(1'b1, a, CSR_OP_WRITE, d, '0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [NE-1:0] e);
        cyc(1'b1, a, CSR_OP_NONE, 32'd0, e);
    endtask

    task automatic idle(input int n, input logic [NE-1:0] e);
        repeat (n) cyc(1'b0, 12'd0, CSR_OP_NONE, 32'd0, e);
    endtask

    initial begin
        m_reset();
        acc = 1'b1; addr = 12'h780;
        #2;
        check("rst_ovf", ovf, 64'd0);
        check("rst_irq", irq, 64'd0);
        check("rst_cntlo", rdata, 64'd0);
        acc = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Basic counting of event 3.
        wr(12'h7A0, 32'h1);
        wr(12'h790, 32'h103);
        idle(5, 16'h0008);
        idle(1, 16'h0000);
        rd(12'h780, '0);
        check("t1_cnt", last_rd, 64'd5);
        check("t1_ovf", last_ovf, 64'd0);

        // Wrap on overflow with interrupt, then clear.
        wr(12'h781, 32'hFFFF_FFFF);
        wr(12'h789, 32'h0000_FFFF);
        wr(12'h791, 32'h503);
        idle(1, 16'h0008);
        idle(1, 16'h0000);
        rd(12'h781, '0);
        check("t2_lo", last_rd, 64'd0);
        check("t2_ovf", last_ovf[1], 64'd1);
        check("t2_irq", last_irq, 64'd1);
        rd(12'h789, '0);
        check("t2_hi", last_rd, 64'd0);
        cyc(1'b1, 12'h7A1, CSR_OP_CLEAR, 32'h2, '0);
        idle(1, '0);
        check("t2_ovf_clr", last_ovf[1], 64'd0);
        check("t2_irq_clr", last_irq, 64'd0);

        // Saturation holds at all-ones.
        wr(12'h791, 32'h703);
        wr(12'h781, 32'hFFFF_FFFF);
        wr(12'h789, 32'h0000_FFFF);
        idle(1, 16'h0008);
        idle(1, '0);
        rd(12'h781, '0);
        check("t3_lo", last_rd, 64'hFFFF_FFFF);
        check("t3_ovf", last_ovf[1], 64'd1);
        rd(12'h789, '0);
        check("t3_hi", last_rd, 64'hFFFF);
        idle(3, 16'h0008);
        idle(1, '0);
        rd(12'h781, '0);
        check("t3_hold_lo", last_rd, 64'hFFFF_FFFF);
        rd(12'h789, '0);
        check("t3_hold_hi", last_rd, 64'hFFFF);
        cyc(1'b1, 12'h7A1, CSR_OP_CLEAR, 32'h2, '0);
        wr(12'h791, 32'h0);

        // Atomic high-word read through the shadow.
        wr(12'h792, 32'h103);
        wr(12'h782, 32'hFFFF_FFFF);
        wr(12'h78A, 32'h1);
        rd(12'h782, 16'h0008);
        check("t4_lo", last_rd, 64'hFFFF_FFFF);
        idle(1, '0);
        rd(12'h78A, '0);
        check("t4_shadow", last_rd, 64'd1);
        wr(12'h782, 32'h0);
        rd(12'h78A, '0);
        check("t4_live", last_rd, 64'd2);

        // CNTLO write beats a same-cycle increment; unimplemented index.
        idle(1, 16'h0008);
        wr(12'h780, 32'h10);
        rd(12'h780, '0);
        check("t5_wr_wins", last_rd, 64'h10);
        rd(12'h784, '0);
        check("t5_nohit", last_hit, 64'd0);
        check("t5_norddata", last_rd, 64'd0);
        wr(12'h784, 32'hFFFF);
        rd(12'h780, '0);
        check("t5_noeffect", last_rd, 64'h10);

        // Freeze on overflow.
        for (int j = 0; j < NC; j++) begin
            wr(12'h790 + 12'(j), 32'h0);
            wr(12'h780 + 12'(j), 32'h0);
            wr(12'h788 + 12'(j), 32'h0);
        end
        wr(12'h7A1, 32'h0);
        wr(12'h780, 32'hFFFF_FFFF);
        wr(12'h788, 32'h0000_FFFF);
        wr(12'h790, 32'h503);
        for (int j = 1; j < NC; j++) wr(12'h790 + 12'(j), 32'h104);
        wr(12'h7A0, 32'h3);
        idle(1, 16'h0018);
        idle(6, 16'h0010);
        check("t6_irq", last_irq, 64'd1);
        rd(12'h781, '0);
        check("t6_frozen", last_rd, 64'd2);
        cyc(1'b1, 12'h7A1, CSR_OP_CLEAR, 32'h1, 16'h0010);
        idle(4, 16'h0010);
        idle(1, '0);
        rd(12'h781, '0);
        check("t6_resume", last_rd, 64'd6);

        // Random CSR and event traffic.
        for (int n = 0; n < 3000; n++) begin
            int r = $urandom_range(0, 9);
            int ix = $urandom_range(0, 7);
            logic [11:0] a;
            logic [31:0] d;
            bit aa = 1'b1;
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: d = 32'hFFFF_FFFF;
                2: d = 32'h0000_FFFF;
                default: d = ($urandom & 32'h8000_0700) | 32'($urandom_range(0, 19));
            endcase
            case (r)
                0, 1: a = 12'h780 + 12'(ix);
                2:    a = 12'h788 + 12'(ix);
                3, 4: a = 12'h790 + 12'(ix);
                5:    a = 12'h7A0;
                6:    a = 12'h7A1;
                7:    a = 12'($urandom);
                default: begin a = 12'd0; aa = 1'b0; end
            endcase
            cyc(aa, a, 2'($urandom_range(0, 3)), d, NE'($urandom));
        end

        // Asynchronous reset with an increment in flight.
        wr(12'h7A0, 32'h1);
        wr(12'h790, 32'h103);
        idle(1, 16'h0008);
        rst_n = 1'b0;
        acc = 1'b1; addr = 12'h780; op = CSR_OP_NONE; ev = '0;
        #1;
        check("mid_rst_ovf", ovf, 64'd0);
        check("mid_rst_irq", irq, 64'd0);
        check("mid_rst_cnt", rdata, 64'd0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, '0);
        rd(12'h780, '0);
        check("post_rst_cnt", last_rd, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
